// File: rtl/fir_64_mdc_engine_ctrl.sv
// Run controller for the FIR MDC kernel: gates x/y streams for a limited number of y beats per run.
// x path combinational pass-through; y path through a one-entry register with full throughput.
module fir_64_mdc_engine_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  ctrl_start_i,
  input  logic                  ctrl_clear_i,
  input  logic                  ctrl_enable_i,
  input  logic [CNT_WIDTH-1:0]  ctrl_cnt_limit_i,
  output logic                  flags_ready_o,
  output logic [CNT_WIDTH-1:0]  flags_cnt_o,
  output logic                  flags_done_o,
  input  logic                  x_valid_i,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  output logic                  x_ready_o,
  output logic                  k_x_valid_o,
  output logic [DATA_WIDTH-1:0] k_x_data_o,
  input  logic                  k_x_ready_i,
  input  logic                  k_y_valid_i,
  input  logic [DATA_WIDTH-1:0] k_y_data_i,
  output logic                  k_y_ready_o,
  output logic                  y_valid_o,
  output logic [DATA_WIDTH-1:0] y_data_o,
  input  logic                  y_ready_i,
  output logic                  k_start_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_limit;
  logic [CNT_WIDTH-1:0]  r_acc_cnt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic                  r_k_start;
  logic                  r_done;
  logic                  r_ready;

  logic w_soft_rst;
  logic w_start;
  logic w_kick;
  logic w_run_en;
  logic w_ky_hs;
  logic w_y_hs;

  assign w_soft_rst = !rst_ni || clear_i;
  assign w_start    = (r_state == S_IDLE) && ctrl_start_i && ctrl_enable_i && !ctrl_clear_i;
  assign w_kick     = w_start && (ctrl_cnt_limit_i != '0);
  // x and kernel-y traffic only while beats are still owed for this run
  assign w_run_en   = (r_state == S_RUN) && ctrl_enable_i && (r_acc_cnt < r_limit);

  assign x_ready_o   = w_run_en && k_x_ready_i;
  assign k_x_valid_o = w_run_en && x_valid_i;
  assign k_x_data_o  = x_data_i;
  assign k_y_ready_o = w_run_en && (!r_out_vld || y_ready_i);
  assign y_valid_o   = r_out_vld;
  assign y_data_o    = r_out_dat;

  assign w_ky_hs = k_y_valid_i && k_y_ready_o;
  assign w_y_hs  = r_out_vld && y_ready_i;

  assign flags_ready_o = r_ready;
  assign flags_cnt_o   = r_cnt;
  assign flags_done_o  = r_done;
  assign k_start_o     = r_k_start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = (ctrl_cnt_limit_i != '0) ? S_RUN : S_DONE;
      S_RUN:  if (r_cnt == r_limit) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (ctrl_clear_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (w_soft_rst) begin
      r_state   <= S_IDLE;
      r_limit   <= '0;
      r_acc_cnt <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_k_start <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_k_start <= w_kick;
      r_done    <= (w_state_nxt == S_DONE);
      r_ready   <= (w_state_nxt == S_IDLE);
      if (ctrl_clear_i) begin
        r_acc_cnt <= '0;
        r_cnt     <= '0;
        r_out_vld <= 1'b0;
      end else if (w_start) begin
        r_limit   <= ctrl_cnt_limit_i;
        r_acc_cnt <= '0;
        r_cnt     <= '0;
        r_out_vld <= 1'b0;
      end else begin
        if (w_ky_hs && (r_acc_cnt < r_limit)) r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
        if (w_y_hs && (r_cnt < r_limit))      r_cnt     <= r_cnt + CNT_WIDTH'(1);
        // a new kernel beat may replace the one leaving in the same cycle
        if (w_ky_hs) begin
          r_out_vld <= 1'b1;
          r_out_dat <= k_y_data_i;
        end else if (w_y_hs) begin
          r_out_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_64_mdc_engine_ctrl.sv
// Randomized bench: the bench plays streamer, kernel and sink, and scores y beats against the x beats fed in.
module tb_fir_64_mdc_engine_ctrl;
  localparam int CW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i, ctrl_start_i, ctrl_clear_i, ctrl_enable_i;
  logic [CW-1:0] ctrl_cnt_limit_i;
  logic          flags_ready_o, flags_done_o, k_start_o;
  logic [CW-1:0] flags_cnt_o;
  logic          x_valid_i, x_ready_o, k_x_valid_o, k_x_ready_i;
  logic          k_y_valid_i, k_y_ready_o, y_valid_o, y_ready_i;
  logic [DW-1:0] x_data_i, k_x_data_o, k_y_data_i, y_data_o;

  fir_64_mdc_engine_ctrl #(.CNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .ctrl_start_i(ctrl_start_i), .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i),
    .ctrl_cnt_limit_i(ctrl_cnt_limit_i),
    .flags_ready_o(flags_ready_o), .flags_cnt_o(flags_cnt_o), .flags_done_o(flags_done_o),
    .x_valid_i(x_valid_i), .x_data_i(x_data_i), .x_ready_o(x_ready_o),
    .k_x_valid_o(k_x_valid_o), .k_x_data_o(k_x_data_o), .k_x_ready_i(k_x_ready_i),
    .k_y_valid_i(k_y_valid_i), .k_y_data_i(k_y_data_i), .k_y_ready_o(k_y_ready_o),
    .y_valid_o(y_valid_o), .y_data_o(y_data_o), .y_ready_i(y_ready_i),
    .k_start_o(k_start_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard state
  logic [DW-1:0] sent[$];
  logic [DW-1:0] kq[$];
  int            yidx, acc_m, prev_cnt, cur_cyc, first_y, last_y;
  logic          stall_prev;
  logic [DW-1:0] stall_dat;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] kfun(input logic [DW-1:0] x);
    return (x * 32'd3) ^ 32'h5a5a_00ff;
  endfunction

  task automatic drive(input bit en, input bit yrdy, input bit always_rdy);
    ctrl_enable_i = en;
    y_ready_i     = yrdy;
    x_valid_i     = always_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    x_data_i      = $urandom;
    k_x_ready_i   = always_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    k_y_valid_i   = (kq.size() > 0) && (always_rdy || ($urandom_range(0, 3) != 0));
    k_y_data_i    = (kq.size() > 0) ? kq[0] : $urandom;
  endtask

  task automatic observe(input int lim, input bit gap, input bit stall);
    logic x_hs, kx_hs, ky_hs, y_hs;
    #1;
    x_hs  = x_valid_i && x_ready_o;
    kx_hs = k_x_valid_o && k_x_ready_i;
    ky_hs = k_y_valid_i && k_y_ready_o;
    y_hs  = y_valid_o && y_ready_i;
    check("x_pass_hs", x_hs, kx_hs);
    if (gap) begin
      check("gap_kx_hs", kx_hs, 0);
      check("gap_ky_rdy", k_y_ready_o, 0);
    end
    if (stall) check("stall_ky_rdy", k_y_ready_o, 0);
    if (ky_hs) begin
      check("acc_bound", acc_m < lim, 1);
      if (kq.size() > 0) void'(kq.pop_front());
      acc_m++;
    end
    if (kx_hs) begin
      check("kx_data", k_x_data_o, x_data_i);
      sent.push_back(x_data_i);
      kq.push_back(kfun(x_data_i));
    end
    if (y_hs) begin
      if (yidx < sent.size()) check("y_data", y_data_o, kfun(sent[yidx]));
      else check("y_extra", yidx, sent.size());
      if (first_y < 0) first_y = cur_cyc;
      last_y = cur_cyc;
      yidx++;
    end
    stall_prev = y_valid_o && !y_ready_i;
    stall_dat  = y_data_o;
  endtask

  task automatic check_idle_blocked(input string tag);
    x_valid_i = 1'b1; k_x_ready_i = 1'b1; k_y_valid_i = 1'b1; k_y_data_i = $urandom;
    #1;
    check({tag, "_x_rdy"}, x_ready_o, 0);
    check({tag, "_kx_vld"}, k_x_valid_o, 0);
    check({tag, "_ky_rdy"}, k_y_ready_o, 0);
  endtask

  // abort_kind: 0 none, 1 ctrl_clear_i, 2 rst_ni, 3 clear_i
  task automatic run_case(input int lim, input bit always_rdy, input int gap_at,
                          input int stall_beat, input int abort_at, input int abort_kind);
    bit done_seen = 0;
    bit stall_done = 0;
    int stall_left = 0;
    bit gap, stall;
    sent.delete(); kq.delete();
    yidx = 0; acc_m = 0; stall_prev = 0; first_y = -1; last_y = -1;

    @(negedge clk_i);
    check("idle_ready", flags_ready_o, 1);
    check("cnt_hold", flags_cnt_o, prev_cnt);
    check_idle_blocked("idle");
    ctrl_cnt_limit_i = lim;
    ctrl_start_i = 1'b1;
    ctrl_enable_i = 1'b1;
    @(negedge clk_i);
    ctrl_start_i = 1'b0;
    ctrl_cnt_limit_i = $urandom;
    check("k_start", k_start_o, lim != 0);
    check("start_busy", flags_ready_o, 0);
    check("start_cnt", flags_cnt_o, 0);
    if (lim == 0) begin
      check("lim0_done", flags_done_o, 1);
      check_idle_blocked("lim0");
      @(negedge clk_i);
      check("lim0_ready", flags_ready_o, 1);
      check("lim0_done_off", flags_done_o, 0);
      check("lim0_kstart", k_start_o, 0);
      prev_cnt = 0;
      return;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      cur_cyc = cyc;
      if (cyc > 0) @(negedge clk_i);
      if (flags_done_o) begin
        done_seen = 1;
        check("done_cnt", flags_cnt_o, lim);
        check("done_busy", flags_ready_o, 0);
        break;
      end
      check("cnt", flags_cnt_o, yidx);
      check("y_valid", y_valid_o, acc_m > yidx);
      check("busy", flags_ready_o, 0);
      if (cyc > 0) check("k_start_once", k_start_o, 0);
      if (stall_prev) begin
        check("hold_valid", y_valid_o, 1);
        check("hold_data", y_data_o, stall_dat);
      end
      if (abort_kind != 0 && yidx == abort_at) begin
        drive(1'b1, 1'b0, always_rdy);
        case (abort_kind)
          1: ctrl_clear_i = 1'b1;
          2: rst_ni = 1'b0;
          default: clear_i = 1'b1;
        endcase
        @(negedge clk_i);
        ctrl_clear_i = 1'b0; rst_ni = 1'b1; clear_i = 1'b0;
        kq.delete();
        check("abort_ready", flags_ready_o, 1);
        check("abort_cnt", flags_cnt_o, 0);
        check("abort_yvld", y_valid_o, 0);
        check("abort_kstart", k_start_o, 0);
        check("abort_done", flags_done_o, 0);
        if (abort_kind != 1) check("abort_ydat", y_data_o, 0);
        check_idle_blocked("abort");
        @(negedge clk_i);
        check("abort_stay_idle", flags_ready_o, 1);
        check("abort_stay_yvld", y_valid_o, 0);
        prev_cnt = 0;
        return;
      end
      gap = (gap_at >= 0) && (cyc >= gap_at) && (cyc < gap_at + 3);
      if (stall_beat >= 0 && !stall_done && yidx == stall_beat && y_valid_o) begin
        stall_left = 5;
        stall_done = 1;
      end
      stall = (stall_left > 0);
      if (stall) stall_left--;
      drive(!gap, stall ? 1'b0 : (always_rdy ? 1'b1 : ($urandom_range(0, 3) != 0)), always_rdy);
      observe(lim, gap, stall);
    end
    check("done_seen", done_seen, 1);
    check("y_total", yidx, lim);
    check("acc_total", acc_m, lim);
    if (always_rdy && gap_at < 0 && stall_beat < 0) check("y_consec", last_y - first_y, lim - 1);
    @(negedge clk_i);
    check("end_ready", flags_ready_o, 1);
    check("end_done_off", flags_done_o, 0);
    check("end_cnt_hold", flags_cnt_o, lim);
    prev_cnt = lim;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; ctrl_start_i = 1'b0; ctrl_clear_i = 1'b0;
    ctrl_enable_i = 1'b1; ctrl_cnt_limit_i = '0;
    x_valid_i = 1'b0; x_data_i = '0; k_x_ready_i = 1'b0;
    k_y_valid_i = 1'b0; k_y_data_i = '0; y_ready_i = 1'b0;
    prev_cnt = 0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    check("rst_ready", flags_ready_o, 1);
    check("rst_cnt", flags_cnt_o, 0);
    check("rst_done", flags_done_o, 0);
    check("rst_kstart", k_start_o, 0);
    check("rst_yvld", y_valid_o, 0);
    check("rst_ydat", y_data_o, 0);

    run_case(4, 1'b1, -1, -1, -1, 0);
    run_case(3, 1'b1, -1, 1, -1, 0);
    run_case(8, 1'b1, 4, -1, -1, 0);
    run_case(0, 1'b1, -1, -1, -1, 0);

    // clear and start together in IDLE: clear wins
    @(negedge clk_i);
    ctrl_start_i = 1'b1; ctrl_clear_i = 1'b1; ctrl_cnt_limit_i = 5;
    @(negedge clk_i);
    ctrl_start_i = 1'b0; ctrl_clear_i = 1'b0;
    check("clr_start_ready", flags_ready_o, 1);
    check("clr_start_kstart", k_start_o, 0);
    check("clr_start_cnt", flags_cnt_o, 0);
    @(negedge clk_i);
    check("clr_start_stay", flags_ready_o, 1);
    check("clr_start_done", flags_done_o, 0);
    prev_cnt = 0;

    run_case(5, 1'b1, -1, -1, 2, 1);
    run_case(6, 1'b1, -1, -1, 3, 2);
    run_case(2, 1'b1, -1, -1, -1, 0);
    run_case(4, 1'b0, -1, -1, 1, 3);

    for (int r = 0; r < 12; r++) begin
      run_case($urandom_range(1, 12), 1'b0,
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, 10) : -1,
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_64_mdc_engine_ctrl.md
FIR_64_MDC_ENGINE_CTRL -- requirements
Module: fir_64_mdc_engine_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of output-beat counter and limit.
REQ-002 Parameter DATA_WIDTH, default 32: stream data width.
REQ-003 Single clock domain; reset is synchronous and active-low.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 clear_i  in  1  global soft clear, same effect as reset.
REQ-007 ctrl_start_i  in  1  run request from control FSM.
REQ-008 ctrl_clear_i  in  1  engine clear (counters, datapath).
REQ-009 ctrl_enable_i  in  1  handshake enable.
REQ-010 ctrl_cnt_limit_i  in  CNT_WIDTH  number of y_V beats per run.
REQ-011 flags_ready_o  out  1  engine idle, able to accept start.
REQ-012 flags_cnt_o  out  CNT_WIDTH  y_V beats delivered in current run.
REQ-013 flags_done_o  out  1  one-cycle run-complete pulse.
REQ-014 x_valid_i / x_data_i[DATA_WIDTH] / x_ready_o: x_V input stream from streamer.
REQ-015 k_x_valid_o / k_x_data_o[DATA_WIDTH] / k_x_ready_i: x_V to MDC kernel.
REQ-016 k_y_valid_i / k_y_data_i[DATA_WIDTH] / k_y_ready_o: y_V from MDC kernel.
REQ-017 y_valid_o / y_data_o[DATA_WIDTH] / y_ready_i: y_V output stream to streamer.
REQ-018 k_start_o  out  1  one-cycle kernel start pulse.

Function
REQ-019 States: IDLE, RUN, DONE; all outputs registered except stream pass-through valid/ready/data.
REQ-020 IDLE: flags_ready_o=1; all handshakes blocked (x_ready_o=0, k_x_valid_o=0, k_y_ready_o=0).
REQ-021 IDLE, ctrl_start_i=1, ctrl_clear_i=0, ctrl_enable_i=1, limit!=0: next RUN; limit latched; k_start_o=1 next cycle only.
REQ-022 IDLE, start with limit==0: next DONE; no kernel start, no handshakes.
REQ-023 ctrl_start_i ignored outside IDLE; flags_ready_o=0 in RUN and DONE.
REQ-024 RUN, enable=1, acc_cnt<limit: x pass-through combinational -- k_x_valid_o=x_valid_i, x_ready_o=k_x_ready_i, k_x_data_o=x_data_i.
REQ-025 Once acc_cnt==limit, x_ready_o=0 and k_x_valid_o=0.
REQ-026 One-entry output register (out_valid, out_data) between kernel y and y stream; y_valid_o=out_valid, y_data_o=out_data.
REQ-027 k_y_ready_o = RUN & enable & (acc_cnt<limit) & (~out_valid | y_ready_i); full throughput, one beat per cycle.
REQ-028 acc_cnt increments on k_y handshake; flags_cnt_o increments on y_valid_o & y_ready_i; both saturate at latched limit.
REQ-029 enable=0: x and k_y handshakes blocked; y side unaffected, held beat stays valid with stable data until accepted.
REQ-030 RUN -> DONE when flags_cnt_o==limit (last y beat accepted); DONE: flags_done_o=1 one cycle, next IDLE.
REQ-031 flags_cnt_o holds final value in IDLE until ctrl_clear_i, so control sees cnt==limit.
REQ-032 ctrl_clear_i=1 in any state: next IDLE, acc_cnt=0, flags_cnt_o=0, out_valid=0, k_start_o=0; clear wins over simultaneous start.
REQ-033 Limit latched at start; ctrl_cnt_limit_i changes mid-run ignored.

Reset
REQ-034 rst_ni=0 or clear_i=1 at clock edge: state IDLE, flags_cnt_o=0, acc_cnt=0, out_valid=0, out_data=0, k_start_o=0, flags_done_o=0, flags_ready_o=1.
REQ-035 Reset mid-RUN drops any held y beat; no y_valid_o in the cycle after reset.

Verification
REQ-036 limit=4, kernel and sink always ready, start -> k_start_o 1 cycle, 4 y beats on consecutive cycles, flags_cnt_o 1..4, flags_done_o pulse, IDLE with cnt=4.
REQ-037 limit=3, y_ready_i low 5 cycles on beat 2 -> y_valid_o/y_data_o stable, k_y_ready_o=0, no beat lost or duplicated, cnt ends 3.
REQ-038 limit=8, enable dropped 3 cycles mid-run -> no x/k_y handshakes during gap, pending y beat still delivered, cnt ends 8.
REQ-039 start with limit=0 -> DONE next cycle, done pulse, no k_start_o, no handshakes.
REQ-040 ctrl_clear_i and ctrl_start_i same cycle in IDLE -> stays IDLE, cnt=0; clear asserted at cnt=2 of limit 5 -> IDLE, cnt=0, y_valid_o=0.
REQ-041 rst_ni low one cycle mid-RUN at cnt=3 -> all REQ-034 values next cycle; subsequent start with limit=2 completes normally.
